isqrt_seq: RTL and testbench

ISQRT_SEQ -- requirements
Module: isqrt_seq

---
 rtl/isqrt_pkg.sv | 15 +
 rtl/isqrt_step.sv | 30 +++
 rtl/isqrt_seq.sv | 102 ++++++++++
 tb/tb_isqrt_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | isqrt_pkg : shared types for the sequential integer square root  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/isqrt_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | isqrt_step : one restoring square-root digit step (combinational)|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module isqrt_step #(
  parameter int W = 32
) (
  input  logic [W/2+1:0] i_rem,
  input  logic [W/2-1:0] i_root,
  input  logic [1:0]     i_bits,
  output logic [W/2+1:0] o_rem,
  output logic [W/2-1:0] o_root
);

  localparam int H = W / 2;

  logic [H+1:0] w_rem_sh;
  logic [H+1:0] w_trial;
  logic         w_ge;

  // Remainder never exceeds 2*root, so the bits shifted out are always zero.
  assign w_rem_sh = (i_rem << 2) | {{H{1'b0}}, i_bits};
  assign w_trial  = {i_root, 2'b01};
  assign w_ge     = (w_rem_sh >= w_trial);
  assign o_rem    = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign o_root   = (i_root << 1) | {{(H-1){1'b0}}, w_ge};

endmodule
`default_nettype wire

// File: rtl/isqrt_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | isqrt_seq : sequential floor(sqrt(x)), two radicand bits / cycle |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_vld,
  input  logic [W-1:0]     x,
  output logic             y_vld,
  output logic [W/2-1:0]   y,
  output logic             busy,
  output logic             drop_err
);

  localparam int H  = W / 2;
  localparam int CW = $clog2(H);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [H+1:0]  r_rem;
  logic [H-1:0]  r_root;
  logic [W-1:0]  r_x;
  logic [H-1:0]  r_y;
  logic          r_y_vld;
  logic          r_busy;
  logic          r_drop;

  logic [H+1:0]  w_rem_nxt;
  logic [H-1:0]  w_root_nxt;
  logic          w_accept;
  logic          w_last;

  isqrt_step #(.W(W)) u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_bits (r_x[W-1:W-2]),
    .o_rem  (w_rem_nxt),
    .o_root (w_root_nxt)
  );

  assign w_accept = x_vld && (r_state != CALC);
  assign w_last   = (r_state == CALC) && (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (x_vld) w_state_nxt = CALC;
      CALC:    if (r_cnt == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = x_vld ? CALC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_y_vld <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_y_vld <= w_last;
      r_busy  <= (w_state_nxt == CALC);
      if (w_last) r_y <= w_root_nxt;
      // Requests during iteration are discarded but remembered.
      if (x_vld && (r_state == CALC)) r_drop <= 1'b1;
      if (w_accept) begin
        r_x    <= x;
        r_rem  <= '0;
        r_root <= '0;
        r_cnt  <= CW'(H - 1);
      end else if (r_state == CALC) begin
        r_x    <= r_x << 2;
        r_rem  <= w_rem_nxt;
        r_root <= w_root_nxt;
        r_cnt  <= r_cnt - 1'b1;
      end
    end
  end

  assign y_vld    = r_y_vld;
  assign y        = r_y;
  assign busy     = r_busy;
  assign drop_err = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_isqrt_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_isqrt_seq : scoreboard bench for isqrt_seq (W=32)             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_isqrt_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_vld = 1'b0;
  logic [31:0] x = '0;
  logic        y_vld;
  logic [15:0] y;
  logic        busy;
  logic        drop_err;

  isqrt_seq #(.W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .x_vld    (x_vld),
    .x        (x),
    .y_vld    (y_vld),
    .y        (y),
    .busy     (busy),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] y;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          n_tot = 0;
  int          n_bad = 0;
  int          calc_end = -1;
  logic [15:0] exp_y = '0;
  logic        exp_drop = 1'b0;
  bit          chk_en = 1'b0;

  function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
    longint r;
    longint lv;
    lv = longint'(v);
    r  = longint'($sqrt(real'(lv)));
    while (r * r > lv) r--;
    while ((r + 1) * (r + 1) <= lv) r++;
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One cycle: check this cycle's outputs, then drive this cycle's inputs.
  task automatic drive(input logic v, input logic [31:0] xv, input logic r);
    exp_t e;
    logic ev;
    @(negedge clk);
    if (chk_en) begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("y_vld", 64'(y_vld), 64'(ev));
      if (ev) begin
        exp_y = q[0].y;
        void'(q.pop_front());
      end
      chk("y", 64'(y), 64'(exp_y));
      chk("busy", 64'(busy), 64'(cyc <= calc_end));
      chk("drop_err", 64'(drop_err), 64'(exp_drop));
    end
    rst   = r;
    x_vld = v;
    x     = xv;
    if (r) begin
      q.delete();
      calc_end = cyc;
      exp_y    = '0;
      exp_drop = 1'b0;
      chk_en   = 1'b1;
    end else if (v) begin
      if (cyc <= calc_end) begin
        exp_drop = 1'b1;
      end else begin
        calc_end = cyc + 16;
        e.y   = ref_sqrt(xv);
        e.due = cyc + 17;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
  endtask

  task automatic req(input logic [31:0] xv);
    drive(1'b1, xv, 1'b0);
  endtask

  initial begin
    logic [31:0] dir_x [7];
    dir_x = '{32'd0, 32'd1, 32'd15, 32'd16, 32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000};

    repeat (3) drive(1'b0, '0, 1'b1);

    // Request in the first cycle after reset, then sequential directed values.
    for (int i = 0; i < 7; i++) begin
      req(dir_x[i]);
      idle(17);
    end

    // Back-to-back: second request lands in the result cycle of the first.
    req(32'd100);
    idle(16);
    req(32'd81);
    idle(18);

    // Request while busy is dropped and flagged.
    req(32'd1000);
    idle(4);
    req(32'd4);
    idle(13);
    idle(2);

    // Reset mid-computation, then restart on the next cycle.
    req(32'd2025);
    idle(7);
    drive(1'b0, '0, 1'b1);
    req(32'd49);
    idle(18);

    for (int i = 0; i < 1500; i++) begin
      req($urandom >> $urandom_range(0, 31));
      idle($urandom_range(0, 20));
    end
    req(32'hFFFF_FFFF);
    idle(20);

    chk("drain", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
